// File: rtl/oup_the_goods.sv
// Pulse/level actuator controller with an Avalon-MM slave: level outputs, queued
// one-shot pulse batches separated by a minimum gap, and a maskable done interrupt.
module oup_the_goods #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned PULSE_LEN = 50000,
  parameter int unsigned GAP_LEN   = 5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_PULSE = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_done;
  logic [WIDTH-1:0] r_readdata;
  logic [CNT_W-1:0] r_cnt;

  logic             w_wr;
  logic             w_wr_level;
  logic             w_wr_pulse;
  logic             w_wr_mask;
  logic             w_wr_done;
  logic             w_cnt_zero;
  logic             w_pend_any;
  logic             w_load_batch;
  logic             w_end_pulse;
  logic             w_cnt_dec;
  logic [WIDTH-1:0] w_rd_mux;

  assign w_wr       = chipselect && !write_n;
  assign w_wr_level = w_wr && (address == ADDR_LEVEL);
  assign w_wr_pulse = w_wr && (address == ADDR_PULSE);
  assign w_wr_mask  = w_wr && (address == ADDR_MASK);
  assign w_wr_done  = w_wr && (address == ADDR_DONE);

  assign w_cnt_zero = (r_cnt == '0);
  assign w_pend_any = |r_pending;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pend_any) w_state_nxt = S_PULSE;
      S_PULSE: if (w_cnt_zero) w_state_nxt = S_GAP;
      S_GAP: begin
        if (w_cnt_zero) w_state_nxt = w_pend_any ? S_PULSE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM control strobes for the datapath
  always_comb begin
    w_load_batch = 1'b0;
    w_end_pulse  = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      S_IDLE:  w_load_batch = w_pend_any;
      S_PULSE: begin
        w_end_pulse = w_cnt_zero;
        w_cnt_dec   = !w_cnt_zero;
      end
      S_GAP: begin
        w_load_batch = w_cnt_zero && w_pend_any;
        w_cnt_dec    = !w_cnt_zero;
      end
      default: ;
    endcase
  end

  // Register read mux, sampled every edge regardless of chipselect
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_LEVEL: w_rd_mux = r_level;
      ADDR_PULSE: w_rd_mux = r_pending | r_active;
      ADDR_MASK:  w_rd_mux = r_mask;
      ADDR_DONE:  w_rd_mux = r_done;
      default:    w_rd_mux = '0;
    endcase
  end

  // Datapath; a pulse write landing on a batch load goes to the next batch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level    <= '0;
      r_pending  <= '0;
      r_active   <= '0;
      r_mask     <= '0;
      r_done     <= '0;
      r_readdata <= '0;
      r_cnt      <= '0;
    end else begin
      r_pending <= (w_load_batch ? '0 : r_pending) | (w_wr_pulse ? writedata : '0);

      if (w_load_batch) begin
        r_active <= r_pending;
      end else if (w_end_pulse) begin
        r_active <= '0;
      end

      if (w_load_batch) begin
        r_cnt <= PULSE_LOAD;
      end else if (w_end_pulse) begin
        r_cnt <= GAP_LOAD;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_wr_level) r_level <= writedata;
      if (w_wr_mask)  r_mask  <= writedata;

      // Software clear beats a batch completing on the same edge
      if (w_wr_done) begin
        r_done <= '0;
      end else if (w_end_pulse) begin
        r_done <= r_done | r_active;
      end

      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_level | r_active;
  assign irq      = |(r_done & r_mask);

endmodule

// File: tb/tb_oup_the_goods.sv
// Directed bench for oup_the_goods with WIDTH=3, PULSE_LEN=4, GAP_LEN=2.
module tb_oup_the_goods;

  logic       clk;
  logic       reset;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [2:0] writedata;
  logic [2:0] readdata;
  logic [2:0] out_port;
  logic       irq;

  int n_chk = 0;
  int n_err = 0;

  oup_the_goods #(
    .WIDTH     (3),
    .PULSE_LEN (4),
    .GAP_LEN   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cs;
    logic       wn;
    logic [1:0] addr;
    logic [2:0] wd;
    logic [2:0] e_out;
    logic       e_irq;
    logic [2:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  // Expected out_port after each edge of the hand-written sequences
  logic [2:0] exp_a [14] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
                             3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
  logic [2:0] exp_b [20] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
                             3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                             3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
  logic [2:0] exp_c [8]  = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};

  function automatic vec_t mk(input logic r, input logic cs, input logic wn,
                              input logic [1:0] a, input logic [2:0] d,
                              input logic [2:0] eo, input logic ei, input logic [2:0] er);
    vec_t v;
    v.rst = r; v.cs = cs; v.wn = wn; v.addr = a; v.wd = d;
    v.e_out = eo; v.e_irq = ei; v.e_rd = er;
    return v;
  endfunction

  task automatic drv(input logic r, input logic cs, input logic wn,
                     input logic [1:0] a, input logic [2:0] d);
    reset = r; chipselect = cs; write_n = wn; address = a; writedata = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b1, 2'd0, 3'b000);
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] d);
    drv(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    drv(1'b0, 1'b1, 1'b1, a, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // rst cs wn addr wd | out irq rd
    vecs.push_back(mk(1, 1, 0, 2'd0, 3'b111, 3'b000, 0, 3'b000));
    vecs.push_back(mk(0, 0, 1, 2'd0, 3'b000, 3'b000, 0, 3'b000));
    vecs.push_back(mk(0, 1, 0, 2'd1, 3'b000, 3'b000, 0, 3'b000));
    vecs.push_back(mk(0, 1, 1, 2'd1, 3'b000, 3'b000, 0, 3'b000));
    vecs.push_back(mk(0, 1, 0, 2'd2, 3'b010, 3'b000, 0, 3'b000));
    vecs.push_back(mk(0, 1, 0, 2'd1, 3'b010, 3'b000, 0, 3'b000));
    vecs.push_back(mk(0, 1, 1, 2'd2, 3'b000, 3'b010, 0, 3'b010));
    vecs.push_back(mk(0, 1, 1, 2'd1, 3'b000, 3'b010, 0, 3'b010));
    vecs.push_back(mk(0, 1, 1, 2'd3, 3'b000, 3'b010, 0, 3'b000));
    vecs.push_back(mk(0, 1, 1, 2'd3, 3'b000, 3'b010, 0, 3'b000));
    vecs.push_back(mk(0, 1, 1, 2'd3, 3'b000, 3'b000, 1, 3'b000));
    vecs.push_back(mk(0, 1, 1, 2'd3, 3'b000, 3'b000, 1, 3'b010));
    vecs.push_back(mk(0, 1, 0, 2'd3, 3'b101, 3'b000, 0, 3'b010));
    vecs.push_back(mk(0, 1, 1, 2'd3, 3'b000, 3'b000, 0, 3'b000));
    vecs.push_back(mk(0, 1, 0, 2'd0, 3'b011, 3'b011, 0, 3'b000));
    vecs.push_back(mk(0, 0, 1, 2'd0, 3'b000, 3'b011, 0, 3'b011));
    vecs.push_back(mk(0, 1, 0, 2'd1, 3'b110, 3'b011, 0, 3'b000));
    vecs.push_back(mk(0, 0, 1, 2'd0, 3'b000, 3'b111, 0, 3'b011));
    vecs.push_back(mk(0, 1, 1, 2'd1, 3'b000, 3'b111, 0, 3'b110));
    vecs.push_back(mk(0, 0, 1, 2'd0, 3'b000, 3'b111, 0, 3'b011));
    vecs.push_back(mk(0, 0, 1, 2'd0, 3'b000, 3'b111, 0, 3'b011));
    vecs.push_back(mk(0, 1, 1, 2'd3, 3'b000, 3'b011, 1, 3'b000));
    vecs.push_back(mk(0, 1, 1, 2'd3, 3'b000, 3'b011, 1, 3'b110));
    vecs.push_back(mk(0, 1, 0, 2'd3, 3'b000, 3'b011, 0, 3'b110));
    vecs.push_back(mk(0, 1, 0, 2'd0, 3'b000, 3'b000, 0, 3'b011));
    vecs.push_back(mk(0, 0, 1, 2'd0, 3'b000, 3'b000, 0, 3'b000));

    drv(1'b1, 1'b0, 1'b1, 2'd0, 3'b000);
    tick();

    foreach (vecs[i]) begin
      drv(vecs[i].rst, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
      tick();
      chk($sformatf("vec%0d out_port", i), out_port, vecs[i].e_out);
      chk($sformatf("vec%0d irq", i), {2'b00, irq}, {2'b00, vecs[i].e_irq});
      chk($sformatf("vec%0d readdata", i), readdata, vecs[i].e_rd);
    end

    // Two queued batches: second waits out the gap; readback mid-pulse shows pending|active
    for (int e = 0; e < 14; e++) begin
      if (e == 0)      wr(2'd1, 3'b001);
      else if (e == 2) wr(2'd1, 3'b100);
      else if (e == 3) rd(2'd1);
      else             idle();
      tick();
      chk($sformatf("seqA e%0d out_port", e), out_port, exp_a[e]);
      if (e == 3) chk("seqA pulse readback", readdata, 3'b101);
    end
    rd(2'd3);
    tick();
    chk("seqA done_capture", readdata, 3'b101);
    chk("seqA irq masked", {2'b00, irq}, 3'b000);
    wr(2'd3, 3'b000);
    tick();

    // Write on the transfer edge goes to the next batch; write mid-pulse never extends it
    for (int e = 0; e < 20; e++) begin
      if (e == 0)      wr(2'd1, 3'b001);
      else if (e == 1) wr(2'd1, 3'b010);
      else if (e == 8) wr(2'd1, 3'b100);
      else             idle();
      tick();
      chk($sformatf("seqB e%0d out_port", e), out_port, exp_b[e]);
    end
    wr(2'd2, 3'b111);
    tick();
    rd(2'd3);
    tick();
    chk("seqB done_capture", readdata, 3'b111);
    chk("seqB irq", {2'b00, irq}, 3'b001);
    wr(2'd3, 3'b010);
    tick();
    chk("seqB irq cleared", {2'b00, irq}, 3'b000);

    // Clear on the very edge the pulse ends: completing bits are dropped
    for (int e = 0; e < 8; e++) begin
      if (e == 0)      wr(2'd1, 3'b001);
      else if (e == 5) wr(2'd3, 3'b000);
      else             idle();
      tick();
      chk($sformatf("seqC e%0d out_port", e), out_port, exp_c[e]);
      chk($sformatf("seqC e%0d irq", e), {2'b00, irq}, 3'b000);
    end
    rd(2'd3);
    tick();
    chk("seqC done_capture", readdata, 3'b000);

    // Reset in the second pulse cycle with a batch pending
    for (int e = 0; e < 16; e++) begin
      if (e == 0)      wr(2'd1, 3'b001);
      else if (e == 1) wr(2'd1, 3'b100);
      else if (e == 3) drv(1'b1, 1'b0, 1'b1, 2'd0, 3'b000);
      else             idle();
      tick();
      chk($sformatf("seqD e%0d out_port", e), out_port,
          (e == 1 || e == 2) ? 3'b001 : 3'b000);
      if (e >= 3) chk($sformatf("seqD e%0d irq", e), {2'b00, irq}, 3'b000);
    end
    rd(2'd3);
    tick();
    chk("seqD done_capture", readdata, 3'b000);
    rd(2'd1);
    tick();
    chk("seqD pending", readdata, 3'b000);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
